// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: controller states,
// Q-format constants and a saturating narrow-to-Q helper.
package nn_pkg;

  localparam int unsigned Q_DATA_WIDTH = 16;
  localparam int unsigned Q_FRAC_BITS  = 15;
  localparam int unsigned SAT_IN_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } nn_state_e;

  localparam logic signed [SAT_IN_WIDTH-1:0] SAT_MAX =
    (64'sd1 <<< (Q_DATA_WIDTH - 1)) - 64'sd1;
  localparam logic signed [SAT_IN_WIDTH-1:0] SAT_MIN = -SAT_MAX - 64'sd1;

  // Clamp a wide signed value into the Q_DATA_WIDTH signed range.
  function automatic logic signed [Q_DATA_WIDTH-1:0] sat_q(
    input logic signed [SAT_IN_WIDTH-1:0] v
  );
    logic signed [Q_DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = Q_DATA_WIDTH'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      r = Q_DATA_WIDTH'(SAT_MIN);
    end else begin
      r = Q_DATA_WIDTH'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/q_sat_shift.sv
// Combinational rescale of a wide accumulator back to Q format:
// arithmetic shift right by the fractional bits, then saturate.
module q_sat_shift
  import nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = Q_FRAC_BITS
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DATA_WIDTH-1:0] res_c
);

  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [SAT_IN_WIDTH-1:0] wide;

  assign shifted = acc_i >>> FRAC_BITS;
  assign wide    = SAT_IN_WIDTH'(shifted);
  assign res_c   = DATA_WIDTH'(sat_q(wide));

endmodule

// File: rtl/neuron_mac_seq.sv
// One-neuron dot product: streams activations, fetches matching weights,
// multiply-accumulates through a 3-stage pipeline and returns a saturated Q result.
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int unsigned N_WEIGHT   = 256,
  parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = Q_FRAC_BITS,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic                          x_valid,
  input  logic signed [DATA_WIDTH-1:0]  x_in,
  output logic                          x_ready,
  output logic                          w_ren,
  output logic [$clog2(N_WEIGHT)-1:0]   w_radd,
  input  logic signed [DATA_WIDTH-1:0]  w_rdata,
  output logic                          y_valid,
  output logic signed [DATA_WIDTH-1:0]  y_out,
  input  logic                          y_ready
);

  localparam int unsigned AW = $clog2(N_WEIGHT);
  localparam int unsigned PW = 2 * DATA_WIDTH;

  nn_state_e                     state_q, state_d;
  logic [AW-1:0]                 cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  x_q, x_d;
  logic signed [PW-1:0]          prod_q, prod_d;
  logic                          v0_q, v0_d;
  logic                          v1_q, v1_d;
  logic                          busy_q, busy_d;
  logic                          x_ready_q, x_ready_d;
  logic                          y_valid_q, y_valid_d;
  logic signed [DATA_WIDTH-1:0]  y_q, y_d;
  logic signed [DATA_WIDTH-1:0]  sat_c;
  logic                          accept_c;

  q_sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .acc_i(acc_q),
    .res_c(sat_c)
  );

  assign accept_c = x_valid & x_ready_q;
  assign w_ren    = accept_c;
  assign w_radd   = cnt_q;
  assign busy     = busy_q;
  assign x_ready  = x_ready_q;
  assign y_valid  = y_valid_q;
  assign y_out    = y_q;

  // Next-state: controller plus the capture/multiply/accumulate pipeline.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    x_ready_d = x_ready_q;
    y_valid_d = y_valid_q;
    y_d       = y_q;
    x_d       = accept_c ? x_in : x_q;
    v0_d      = accept_c;
    prod_d    = PW'(x_q) * PW'(w_rdata);
    v1_d      = v0_q;
    acc_d     = v1_q ? (acc_q + ACC_WIDTH'(prod_q)) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          x_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          if (cnt_q == AW'(N_WEIGHT - 1)) begin
            state_d   = ST_DRAIN;
            x_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Both in-flight stages empty means the accumulator holds the full sum.
        if (!v0_q && !v1_q) begin
          state_d   = ST_OUT;
          y_valid_d = 1'b1;
          y_d       = sat_c;
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          state_d   = ST_IDLE;
          y_valid_d = 1'b0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      prod_q    <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      busy_q    <= 1'b0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      prod_q    <= prod_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      busy_q    <= busy_d;
      x_ready_q <= x_ready_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq with a 4-tap registered weight memory and a
// transaction-level reference model of the dot product.
module tb_neuron_mac_seq;

  localparam int N = 4;

  logic               clk     = 1'b0;
  logic               rst     = 1'b1;
  logic               start   = 1'b0;
  logic               x_valid = 1'b0;
  logic signed [15:0] x_in    = '0;
  logic               y_ready = 1'b0;
  logic               busy, x_ready, w_ren, y_valid;
  logic [1:0]         w_radd;
  logic [15:0]        w_rdata;
  logic [15:0]        y_out;

  logic signed [15:0] wmem [N];
  logic signed [15:0] tx   [N];

  int total = 0;
  int bad   = 0;
  int wren_count = 0;
  int radd_log [$];

  always #5 clk = ~clk;

  neuron_mac_seq #(
    .N_WEIGHT  (N),
    .DATA_WIDTH(16),
    .FRAC_BITS (15),
    .ACC_WIDTH (40)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .x_valid(x_valid),
    .x_in   (x_in),
    .x_ready(x_ready),
    .w_ren  (w_ren),
    .w_radd (w_radd),
    .w_rdata(w_rdata),
    .y_valid(y_valid),
    .y_out  (y_out),
    .y_ready(y_ready)
  );

  always @(posedge clk) if (w_ren) w_rdata <= wmem[w_radd];

  // Reference: mode 0 idle, 1 taking taps, 2 draining, 3 result offered.
  int          m_mode  = 0;
  int          m_taps  = 0;
  int          m_edges = 0;
  longint      m_sum   = 0;
  logic [15:0] m_y     = '0;

  function automatic logic [15:0] sat_ref(input longint v);
    longint s;
    s = v >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_taps = 0; m_edges = 0; m_sum = 0; m_y = '0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_taps = 0; m_sum = 0; end
        1: if (x_valid) begin
             m_sum += longint'(x_in) * longint'(wmem[m_taps]);
             m_taps++;
             if (m_taps == N) begin m_mode = 2; m_edges = 0; end
           end
        2: begin
             m_edges++;
             if (m_edges == 3) begin m_mode = 3; m_y = sat_ref(m_sum); end
           end
        default: if (y_ready) m_mode = 0;
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", longint'(busy), 0);
      check("rst_x_ready", longint'(x_ready), 0);
      check("rst_w_ren", longint'(w_ren), 0);
      check("rst_w_radd", longint'(w_radd), 0);
      check("rst_y_valid", longint'(y_valid), 0);
      check("rst_y_out", longint'(y_out), 0);
    end else begin
      check("busy", longint'(busy), longint'(m_mode != 0));
      check("x_ready", longint'(x_ready), longint'(m_mode == 1));
      check("w_ren", longint'(w_ren), longint'(x_valid && m_mode == 1));
      if (x_valid && m_mode == 1) check("w_radd", longint'(w_radd), longint'(m_taps));
      check("y_valid", longint'(y_valid), longint'(m_mode == 3));
      if (m_mode == 3) check("y_out", longint'(y_out), longint'(m_y));
      if (w_ren) begin
        wren_count++;
        radd_log.push_back(int'(w_radd));
      end
    end
  end

  task automatic run_once(input int gap, input int hold, output logic [15:0] y, output int lat);
    int g;
    @(posedge clk); #1 x_valid = 1'b1; x_in = 16'($urandom);
    @(posedge clk); #1 x_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < N; i++) begin
      x_valid = 1'b1; x_in = tx[i];
      @(posedge clk); #1 x_valid = 1'b0; x_in = 16'($urandom);
      if (i < N - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      #1 x_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (y_valid) break;
    end
    x_valid = 1'b0;
    check("y_valid_seen", longint'(y_valid), 1);
    y = y_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1 start = 1'(h % 2 == 0);
      @(negedge clk);
      check("stall_busy", longint'(busy), 1);
      check("stall_y_valid", longint'(y_valid), 1);
      check("stall_y_out", longint'(y_out), longint'(y));
    end
    @(posedge clk); #1 y_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 y_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    check("ack_to_idle", longint'(busy), 0);
  endtask

  task automatic set_basic();
    wmem[0] = 16'sh4000; wmem[1] = 16'shC000; wmem[2] = 16'sh2000; wmem[3] = 16'sh0000;
    for (int i = 0; i < N; i++) tx[i] = 16'sh4000;
  endtask

  logic [15:0] y;
  int lat, w0;

  initial begin
    for (int i = 0; i < N; i++) begin wmem[i] = '0; tx[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic sum, latency and address order.
    set_basic();
    radd_log.delete();
    run_once(0, 0, y, lat);
    check("basic_y", longint'(y), 64'h1000);
    check("basic_model", longint'(m_y), 64'h1000);
    check("basic_latency", longint'(lat), 3);
    check("basic_radd_n", longint'(radd_log.size()), 4);
    for (int i = 0; i < radd_log.size(); i++) check("basic_radd_seq", longint'(radd_log[i]), longint'(i));

    // Bubbles between taps.
    w0 = wren_count;
    run_once(2, 0, y, lat);
    check("stall_y", longint'(y), 64'h1000);
    check("stall_wren_pulses", longint'(wren_count - w0), 4);

    // Positive and negative saturation.
    for (int i = 0; i < N; i++) begin wmem[i] = 16'sh4000; tx[i] = 16'sh4000; end
    run_once(0, 0, y, lat);
    check("sat_pos", longint'(y), 64'h7FFF);
    for (int i = 0; i < N; i++) begin wmem[i] = 16'sh8000; tx[i] = 16'sh7FFF; end
    run_once(1, 0, y, lat);
    check("sat_neg", longint'(y), 64'h8000);

    // Output backpressure for 5 cycles with start pulses.
    set_basic();
    run_once(0, 5, y, lat);
    check("bp_y", longint'(y), 64'h1000);

    // Reset mid-run after 2 taps.
    for (int i = 0; i < N; i++) wmem[i] = 16'sh7FFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; x_valid = 1'b1; x_in = 16'sh7FFF;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; x_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", longint'(busy), 0);
    check("post_rst_y_out", longint'(y_out), 0);
    set_basic();
    run_once(0, 0, y, lat);
    check("rst_run_y", longint'(y), 64'h1000);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        wmem[i] = ($urandom_range(0, 3) == 0) ? 16'sh8000 : 16'($urandom);
        tx[i]   = ($urandom_range(0, 3) == 0) ? 16'sh7FFF : 16'($urandom);
      end
      run_once(-1, int'($urandom_range(0, 3)), y, lat);
      check("rand_latency", longint'(lat), 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Downstream consumer of the weight memory; computes one neuron's dot product over N_WEIGHT taps.
- Accepts a stream of input activations. For each accepted activation it issues a read of the matching weight.
- Multiplies each activation by the returned weight (Q1.15 × Q1.15) and accumulates the products.
- After the last tap it emits one saturated Q1.15 result with a valid/ready handshake.

Parameters:
- N_WEIGHT, 256, taps per neuron; must equal the weight memory depth.
- DATA_WIDTH, 16, width of activations, weights and result; signed.
- FRAC_BITS, 15, fractional bits of the Q format.
- ACC_WIDTH, 40, signed accumulator width; must be at least 2*DATA_WIDTH + clog2(N_WEIGHT).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new dot product; ignored unless the block is IDLE.
- busy  out  1  high in any state other than IDLE.
- x_valid  in  1  activation valid.
- x_in  in  DATA_WIDTH  signed activation.
- x_ready  out  1  high in RUN.
- w_ren  out  1  weight memory read enable.
- w_radd  out  clog2(N_WEIGHT)  weight memory read address.
- w_rdata  in  DATA_WIDTH  weight memory read data; registered, valid one cycle after w_ren.
- y_valid  out  1  result valid; held until accepted.
- y_out  out  DATA_WIDTH  signed saturated result.
- y_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE; tap counter, accumulator and pipeline valid flags clear.
  - busy=0, x_ready=0, w_ren=0, w_radd=0, y_valid=0, y_out=0.
- States: IDLE, RUN, DRAIN, OUT.
  - IDLE → RUN on start=1. On the same edge the accumulator and tap counter clear.
  - RUN → DRAIN on the accept of tap N_WEIGHT-1. An accept is x_valid & x_ready.
  - DRAIN → OUT once the pipeline is empty (two cycles after the last accept).
  - OUT → IDLE on y_valid & y_ready.
- Read issue:
  - w_ren = x_valid & x_ready, combinational.
  - w_radd = tap counter, a registered value.
  - The counter increments on each accept and never wraps inside a run; the final index is N_WEIGHT-1.
- Pipeline:
  - Stage 0 (accept edge): register x_in and set stage-0 valid.
  - Stage 1: product = x_reg * w_rdata, signed 2*DATA_WIDTH wide, registered with its valid flag.
  - Stage 2: accumulator += sign-extended product when the product valid flag is set.
  - Bubbles from x_valid=0 propagate as invalid stages; they never add into the accumulator.
- Result:
  - On entry to OUT, y_out = acc >>> FRAC_BITS (arithmetic shift, truncation toward −inf).
  - The shifted value saturates to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]; for 16 bits that is 0x8000..0x7FFF.
  - y_valid rises at the 3rd rising edge after the edge that accepted the last tap.
- Stall: while y_ready=0 in OUT, y_valid and y_out hold stable and start is ignored.
- Simultaneous events: start arriving in the same cycle that OUT is acknowledged is ignored. A new run requires a start pulse while in IDLE.
- x_valid outside RUN has no effect: no read is issued and the counter does not move.
- Reset mid-operation: the partial sum is discarded. The next start produces a result computed only from the new run.

Decomposition:
- Shared package nn_pkg holds:
  - the state enumeration;
  - Q-format constants (DATA_WIDTH=16, FRAC_BITS=15);
  - a saturate-to-DATA_WIDTH function, reused by later layer blocks.
- One natural sub-module: q_sat_shift. It is combinational: ACC_WIDTH input, arithmetic shift by FRAC_BITS, DATA_WIDTH saturated output.
- The state machine, counter and pipeline stay in neuron_mac_seq.

Test Plan (bench uses N_WEIGHT=4 and a behavioural registered weight memory):
- Reset values: assert rst mid-simulation → all outputs read 0, busy=0; x_valid=1 during reset → w_ren stays 0.
- Basic sum: weights {0x4000,0xC000,0x2000,0x0000}, x=0x4000 on four consecutive cycles → y_out=0x1000; y_valid rises 3 edges after the last accept; w_radd sequence is 0,1,2,3.
- Stalled input: same data with x_valid low for 2 cycles between every tap → same y_out=0x1000; exactly 4 w_ren pulses.
- Saturation: all weights 0x4000 with x=0x4000 → y_out=0x7FFF. All weights 0x8000 with x=0x7FFF → y_out=0x8000.
- Output backpressure: y_ready low for 5 cycles → y_valid and y_out stable, start pulses ignored, busy=1; y_ready=1 → IDLE on the next edge.
- Reset mid-run: assert rst after 2 taps, then start a run with the basic-sum data → y_out=0x1000, with no contribution from the aborted taps.
